rr_arb64_ctrl: RTL and testbench
================================

RR_ARB64_CTRL -- requirements
Module: rr_arb64_ctrl

Interface
REQ-001 Parameter: HOLD_MAX, 255, maximum grant hold in cycles before forced release; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: en  input  1  arbitration enable; when 0, no new grant is issued.
REQ-005 Port: req  input  64  request vector; req[k] is requester k.
REQ-006 Port: done  input  1  single-cycle release pulse from the current grantee.
REQ-007 Port: gnt_valid  output  1  a grant is active.
REQ-008 Port: gnt_idx  output  6  binary index of the granted requester.
REQ-009 Port: gnt_onehot  output  64  one-hot grant; bit gnt_idx set when gnt_valid=1, else all zero.
REQ-010 Port: timeout  output  1  single-cycle pulse on forced release.
REQ-011 Port: busy  output  1  FSM is in state BUSY.

Function
REQ-012 FSM states: IDLE, BUSY; encoding is implementation choice.
REQ-013 IDLE: if en=1 and req!=0, the winner is the first set req bit at or above ptr, searching upward and wrapping 63->0; the FSM enters BUSY.
REQ-014 Grant latency: gnt_valid, gnt_idx and gnt_onehot are registered and appear on the first edge after req is sampled in IDLE.
REQ-015 IDLE with en=0 or req==0: outputs stay zero and ptr holds.
REQ-016 BUSY: gnt_idx is held stable; changes on req bits other than req[gnt_idx] are ignored.
REQ-017 Release occurs on the first of: done=1; req[gnt_idx]=0; hold counter reaching HOLD_MAX.
REQ-018 On release: gnt_valid=0, gnt_onehot=0, ptr=gnt_idx+1 mod 64 (63 wraps to 0), FSM returns to IDLE.
REQ-019 The FSM always spends one IDLE cycle between grants, so back-to-back grants are 2 cycles apart minimum.
REQ-020 Hold counter: 8 bits; cleared on grant; increments each BUSY cycle; forced release when count==HOLD_MAX-1 at the sampling edge, giving exactly HOLD_MAX cycles of gnt_valid.
REQ-021 timeout is high for exactly one cycle, coincident with the first gnt_valid=0 cycle, and only on counter-forced release.
REQ-022 Simultaneous events: if done or req withdrawal coincide with counter expiry, the release is normal and timeout stays 0.
REQ-023 done asserted in IDLE is ignored.
REQ-024 en deasserted during BUSY does not revoke the current grant.
REQ-025 gnt_onehot is produced from the registered gnt_idx gated by gnt_valid and is never multi-hot.

Reset
REQ-026 Assertion of rst_n=0 at any time, including mid-grant, forces: FSM=IDLE, ptr=0, hold counter=0, gnt_valid=0, gnt_idx=0, gnt_onehot=0, timeout=0, busy=0.
REQ-027 The first grant after reset deassertion follows REQ-013 with ptr=0.

Structure
REQ-028 A shared package holds the FSM state typedef, REQ_N=64, IDX_W=6 and CNT_W=8.
REQ-029 One sub-module, onehot_dec6_64, provides the 6-to-64 decode with an enable input driven by gnt_valid.
REQ-030 The round-robin search is a single combinational function of req and ptr; there are no multi-cycle scans.

Verification
REQ-031 Reset, then req[5]=1 with en=1: gnt_idx=5 and gnt_onehot=1<<5 one cycle later; done pulse -> gnt_valid=0 next cycle; ptr=6.
REQ-032 req bits 3, 10 and 40 held high, with done after 2 cycles each: grant order is 3, 10, 40, 3, each separated by one idle cycle.
REQ-033 Wrap-around: ptr=63 (via a grant to 62), then req bits 0 and 63 set: grant 63, then 0; ptr wraps to 0 after releasing 63.
REQ-034 HOLD_MAX=4, req[7] held, no done: gnt_valid high exactly 4 cycles, then timeout pulses 1 cycle; done on cycle 4 -> no timeout.
REQ-035 rst_n pulled low asynchronously mid-BUSY with gnt_idx=20: all outputs 0 immediately without a clock; after release, req[30] gives grant 30 searched from ptr=0.
REQ-036 en=0 with req=all-ones: no grant for 10 cycles; en=1 -> grant to index 0 (ptr=0).

Source files
------------

// File: rtl/rr_arb64_ctrl_pkg.sv
// Shared types, widths and the round-robin search for the 64-way arbiter.
package rr_arb64_ctrl_pkg;

  localparam int REQ_N = 64;
  localparam int IDX_W = 6;
  localparam int CNT_W = 8;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  // Returns {found, idx}: the first set request at or above ptr, wrapping 63->0.
  // Scanning from the farthest offset down lets the nearest hit overwrite the rest.
  function automatic logic [IDX_W:0] rr_pick(input logic [REQ_N-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] k;
    found = 1'b0;
    idx   = '0;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      k = ptr + IDX_W'(i);
      if (req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_arb64_ctrl_dec.sv
// 6-to-64 one-hot decoder; output is all zero while en_i is low.
module onehot_dec6_64
  import rr_arb64_ctrl_pkg::*;
(
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [REQ_N-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arb64_ctrl.sv
// 64-requester round-robin arbiter with bounded grant hold and timeout pulse.
module rr_arb64_ctrl
  import rr_arb64_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [REQ_N-1:0] req,
  input  logic             done,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [REQ_N-1:0] gnt_onehot,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W:0]   pick;
  logic             normal_rel;
  logic             expired;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    timeout_d   = 1'b0;
    pick        = rr_pick(req, ptr_q);
    normal_rel  = done || !req[gnt_idx_q];
    expired     = (cnt_q == HOLD_LAST);

    if (state_q == ST_IDLE) begin
      if (en && pick[IDX_W]) begin
        state_d     = ST_BUSY;
        gnt_valid_d = 1'b1;
        gnt_idx_d   = pick[IDX_W-1:0];
        cnt_d       = '0;
      end
    end else begin
      if (normal_rel || expired) begin
        state_d     = ST_IDLE;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
        ptr_d       = gnt_idx_q + 1'b1;
        cnt_d       = '0;
        // A coincident done or withdrawal wins over expiry: no timeout then.
        timeout_d   = !normal_rel;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      timeout_q   <= timeout_d;
    end
  end

  onehot_dec6_64 u_dec (
    .en_i     (gnt_valid_q),
    .idx_i    (gnt_idx_q),
    .onehot_o (gnt_onehot)
  );

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q == ST_BUSY);

endmodule

// File: tb/tb_rr_arb64_ctrl.sv
// Directed bench for rr_arb64_ctrl with HOLD_MAX=4 and hand-computed expectations.
module tb_rr_arb64_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [63:0] req;
  logic        done;
  logic        gnt_valid;
  logic [5:0]  gnt_idx;
  logic [63:0] gnt_onehot;
  logic        timeout;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  rr_arb64_ctrl #(.HOLD_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compares every output against the expected grant state.
  task automatic expect_out(input string tag, input logic v, input int idx, input logic to);
    logic [63:0] one;
    logic [63:0] exp_oh;
    one    = 64'd1;
    exp_oh = v ? (one << idx) : 64'd0;
    check({tag, ".valid"},   64'(gnt_valid),  64'(v));
    check({tag, ".busy"},    64'(busy),       64'(v));
    check({tag, ".onehot"},  gnt_onehot,      exp_oh);
    check({tag, ".timeout"}, 64'(timeout),    64'(to));
    if (v) check({tag, ".idx"}, 64'(gnt_idx), 64'(idx));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] bit_of(input int k);
    logic [63:0] one;
    one = 64'd1;
    return one << k;
  endfunction

  int order[4] = '{3, 10, 40, 3};

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = '0;
    done  = 1'b0;
    #12;
    expect_out("reset", 1'b0, 0, 1'b0);
    check("reset.idx", 64'(gnt_idx), 64'd0);
    rst_n = 1'b1;

    // Single grant to 5, release by done, then ptr=6 prefers 6 over 5.
    en  = 1'b1;
    req = bit_of(5);
    tick();
    expect_out("g5", 1'b1, 5, 1'b0);
    done = 1'b1;
    tick();
    expect_out("g5.rel", 1'b0, 0, 1'b0);
    done = 1'b0;
    req  = bit_of(5) | bit_of(6);
    tick();
    expect_out("ptr6", 1'b1, 6, 1'b0);
    req = '0;
    tick();
    expect_out("ptr6.withdraw", 1'b0, 0, 1'b0);

    // Rotation 3,10,40,3 from ptr=0; other req changes ignored while busy.
    do_reset();
    req = bit_of(3) | bit_of(10) | bit_of(40);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("rot%0d.grant", i), 1'b1, order[i], 1'b0);
      if (i == 0) req = req | bit_of(1);
      tick();
      expect_out($sformatf("rot%0d.hold", i), 1'b1, order[i], 1'b0);
      req  = bit_of(3) | bit_of(10) | bit_of(40);
      done = 1'b1;
      tick();
      expect_out($sformatf("rot%0d.idle", i), 1'b0, 0, 1'b0);
      done = 1'b0;
    end
    req = '0;

    // done in IDLE is ignored.
    done = 1'b1;
    tick();
    expect_out("idle.done", 1'b0, 0, 1'b0);
    done = 1'b0;

    // Wrap-around: grant 62 -> ptr 63, then 63 before 0, then ptr wraps to 0.
    req = bit_of(62);
    tick();
    expect_out("wrap.g62", 1'b1, 62, 1'b0);
    req = bit_of(0) | bit_of(63);
    tick();
    expect_out("wrap.rel62", 1'b0, 0, 1'b0);
    tick();
    expect_out("wrap.g63", 1'b1, 63, 1'b0);
    done = 1'b1;
    tick();
    expect_out("wrap.rel63", 1'b0, 0, 1'b0);
    done = 1'b0;
    tick();
    expect_out("wrap.g0", 1'b1, 0, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;

    // Forced release after exactly 4 cycles, one-cycle timeout pulse.
    req = bit_of(7);
    tick();
    expect_out("hold.c1", 1'b1, 7, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      expect_out($sformatf("hold.c%0d", c), 1'b1, 7, 1'b0);
    end
    tick();
    expect_out("hold.timeout", 1'b0, 0, 1'b1);
    tick();
    expect_out("hold.regrant", 1'b1, 7, 1'b0);
    tick();
    tick();
    tick();
    expect_out("hold2.c4", 1'b1, 7, 1'b0);
    done = 1'b1;
    tick();
    expect_out("hold2.done_at_expiry", 1'b0, 0, 1'b0);
    done = 1'b0;
    req  = '0;
    tick();
    expect_out("hold2.after", 1'b0, 0, 1'b0);

    // Asynchronous reset mid-grant clears outputs without a clock edge.
    req = bit_of(20);
    tick();
    expect_out("arst.g20", 1'b1, 20, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("arst.now", 1'b0, 0, 1'b0);
    check("arst.idx", 64'(gnt_idx), 64'd0);
    req = bit_of(30);
    #10;
    rst_n = 1'b1;
    tick();
    expect_out("arst.g30", 1'b1, 30, 1'b0);
    req = '0;
    tick();

    // en=0 blocks new grants; first grant after reset goes to 0; en=0 does not revoke.
    do_reset();
    en  = 1'b0;
    req = '1;
    for (int c = 0; c < 10; c++) begin
      tick();
      expect_out($sformatf("en0.c%0d", c), 1'b0, 0, 1'b0);
    end
    en = 1'b1;
    tick();
    expect_out("en1.g0", 1'b1, 0, 1'b0);
    en = 1'b0;
    tick();
    expect_out("en0.keep", 1'b1, 0, 1'b0);
    done = 1'b1;
    tick();
    expect_out("en0.rel", 1'b0, 0, 1'b0);
    done = 1'b0;
    tick();
    expect_out("en0.nogrant", 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
